// File: rtl/game_pkg.sv
// Shared game-level types and screen geometry for the sequencer and the
// doodle/platform datapaths.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        SCROLL = 2'd2,
        OVER   = 2'd3
    } game_state_t;

    localparam int SCREEN_W = 1024;
    localparam int SCREEN_H = 768;
    localparam int SPRITE_H = 80;

    localparam int Y_W     = 10;
    localparam int DX_W    = 9;
    localparam int SCORE_W = 16;

endpackage

// File: rtl/game_controller_frame_tick_gen.sv
// Free-running frame pacer: one-cycle pulse every CLK/FPS clock cycles.
// Also used by the renderer, so it carries no game-specific logic.
module frame_tick_gen #(
    parameter int CLK = 50000000,
    parameter int FPS = 50
) (
    input  logic clk,
    input  logic rst,
    output logic frame_tick
);

    localparam int PERIOD = CLK / FPS;
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count 0..PERIOD-1 and wrap.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign frame_tick = (cnt_q == LAST);

endmodule

// File: rtl/game_controller.sv
// Game sequencer: paces the game with frame ticks, runs IDLE/PLAY/SCROLL/OVER,
// issues camera scroll commands and keeps a saturating score.
module game_controller
    import game_pkg::*;
#(
    parameter int CLK         = 50000000,
    parameter int FPS         = 50,
    parameter int SCROLL_LINE = 300,
    parameter int FLOOR_Y     = 688,
    parameter int OVER_FRAMES = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  delta_x,
    input  logic [9:0]  doodle_y,
    output logic        frame_tick,
    output logic        playing,
    output logic        scroll_valid,
    output logic [9:0]  scroll_amount,
    output logic [15:0] score,
    output logic        game_over,
    output logic        soft_rst
);

    localparam logic [Y_W-1:0] SCROLL_Y = Y_W'(SCROLL_LINE);
    localparam logic [Y_W-1:0] FLOOR_V  = Y_W'(FLOOR_Y);
    localparam int OVC_W = $clog2(OVER_FRAMES + 2);
    localparam logic [OVC_W-1:0] OVC_MAX    = '1;
    localparam logic [OVC_W-1:0] OVC_TARGET = OVC_W'(OVER_FRAMES);

    game_state_t          state_q, state_d;
    logic [OVC_W-1:0]     over_cnt_q, over_cnt_d;
    logic [OVC_W-1:0]     over_cnt_inc;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [Y_W-1:0]       amt_q, amt_d;
    logic                 playing_q, playing_d;
    logic                 scroll_valid_q, scroll_valid_d;
    logic                 game_over_q, game_over_d;
    logic                 soft_rst_q, soft_rst_d;
    logic                 tick;
    logic                 active;

    // Score accumulates in 17 bits and clamps at the 16-bit ceiling.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [Y_W-1:0] b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {{(SCORE_W + 1 - Y_W){1'b0}}, b};
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

    frame_tick_gen #(
        .CLK (CLK),
        .FPS (FPS)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (tick)
    );

    assign active       = (delta_x != '0);
    assign over_cnt_inc = (over_cnt_q == OVC_MAX) ? over_cnt_q : over_cnt_q + 1'b1;

    // Next-state logic; outputs are derived from the next state so they are
    // registered and line up with the state they describe.
    always_comb begin
        state_d    = state_q;
        over_cnt_d = over_cnt_q;
        score_d    = score_q;
        amt_d      = amt_q;
        soft_rst_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick && active) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (tick) begin
                    if (doodle_y >= FLOOR_V) begin
                        state_d    = OVER;
                        over_cnt_d = '0;
                    end else if (doodle_y < SCROLL_Y) begin
                        // The compare guarantees this never underflows.
                        state_d = SCROLL;
                        amt_d   = SCROLL_Y - doodle_y;
                        score_d = sat_add(score_q, SCROLL_Y - doodle_y);
                    end
                end
            end
            SCROLL: begin
                // Single-cycle state; the tick period is far longer, so no tick is missed.
                state_d = PLAY;
            end
            OVER: begin
                if (tick) begin
                    over_cnt_d = over_cnt_inc;
                    if ((over_cnt_inc >= OVC_TARGET) && active) begin
                        state_d    = IDLE;
                        over_cnt_d = '0;
                        score_d    = '0;
                        soft_rst_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        playing_d      = (state_d == PLAY) || (state_d == SCROLL);
        scroll_valid_d = (state_d == SCROLL);
        game_over_d    = (state_d == OVER);
    end

    // State and output registers; reset clears everything, including the score.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            over_cnt_q     <= '0;
            score_q        <= '0;
            amt_q          <= '0;
            playing_q      <= 1'b0;
            scroll_valid_q <= 1'b0;
            game_over_q    <= 1'b0;
            soft_rst_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            over_cnt_q     <= over_cnt_d;
            score_q        <= score_d;
            amt_q          <= amt_d;
            playing_q      <= playing_d;
            scroll_valid_q <= scroll_valid_d;
            game_over_q    <= game_over_d;
            soft_rst_q     <= soft_rst_d;
        end
    end

    assign frame_tick    = tick;
    assign playing       = playing_q;
    assign scroll_valid  = scroll_valid_q;
    assign scroll_amount = amt_q;
    assign score         = score_q;
    assign game_over     = game_over_q;
    assign soft_rst      = soft_rst_q;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller with a fast tick (every 100 cycles) and OVER_FRAMES=3.
// Expected scroll events go into a queue as stimulus is driven and are
// compared when scroll_valid pulses.
module tb_game_controller;

    logic        clk;
    logic        rst;
    logic [8:0]  delta_x;
    logic [9:0]  doodle_y;
    logic        frame_tick;
    logic        playing;
    logic        scroll_valid;
    logic [9:0]  scroll_amount;
    logic [15:0] score;
    logic        game_over;
    logic        soft_rst;

    typedef struct {
        logic [9:0]  amt;
        logic [15:0] score;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   mcnt     = 0;
    int   model_score = 0;

    game_controller #(
        .CLK         (1000),
        .FPS         (10),
        .SCROLL_LINE (300),
        .FLOOR_Y     (688),
        .OVER_FRAMES (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .delta_x       (delta_x),
        .doodle_y      (doodle_y),
        .frame_tick    (frame_tick),
        .playing       (playing),
        .scroll_valid  (scroll_valid),
        .scroll_amount (scroll_amount),
        .score         (score),
        .game_over     (game_over),
        .soft_rst      (soft_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
        end
    endtask

    // Reference tick position: 0..99, restarted by rst.
    always @(posedge clk) begin
        if (rst) mcnt <= 0;
        else     mcnt <= (mcnt == 99) ? 0 : mcnt + 1;
    end

    // Tick placement and scroll scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_tick || (mcnt == 99))
            chk("frame_tick", {31'd0, frame_tick}, {31'd0, (mcnt == 99)});
        if (scroll_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_scroll", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("scroll_amount", {22'd0, scroll_amount}, {22'd0, e.amt});
                chk("scroll_score", {16'd0, score}, {16'd0, e.score});
            end
        end
    end

    function automatic int sat(input int s, input int a);
        return (s + a > 65535) ? 65535 : s + a;
    endfunction

    task automatic push_scroll(input int y);
        exp_t e;
        e.amt       = 10'(300 - y);
        model_score = sat(model_score, 300 - y);
        e.score     = 16'(model_score);
        exp_q.push_back(e);
    endtask

    // Return #1 after the clock edge that follows the next frame_tick.
    task automatic wait_tick();
        int n;
        n = 0;
        @(negedge clk);
        while (frame_tick !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("tick_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_playing"}, {31'd0, playing}, 32'd0);
        chk({tag, "_scroll_valid"}, {31'd0, scroll_valid}, 32'd0);
        chk({tag, "_scroll_amount"}, {22'd0, scroll_amount}, 32'd0);
        chk({tag, "_score"}, {16'd0, score}, 32'd0);
        chk({tag, "_game_over"}, {31'd0, game_over}, 32'd0);
        chk({tag, "_soft_rst"}, {31'd0, soft_rst}, 32'd0);
        chk({tag, "_frame_tick"}, {31'd0, frame_tick}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        delta_x  = '0;
        doodle_y = 10'd400;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Idle with no activity.
        repeat (500) @(negedge clk);
        chk("idle_playing", {31'd0, playing}, 32'd0);
        chk("idle_game_over", {31'd0, game_over}, 32'd0);

        // Activity starts play at the next tick.
        delta_x = 9'd5;
        chk("pre_play", {31'd0, playing}, 32'd0);
        wait_tick();
        chk("play_entry", {31'd0, playing}, 32'd1);
        delta_x = '0;

        // Scroll by 50.
        doodle_y = 10'd250;
        push_scroll(250);
        wait_tick();
        chk("scroll_pulse", {31'd0, scroll_valid}, 32'd1);
        doodle_y = 10'd400;
        @(posedge clk); #1;
        chk("scroll_one_cycle", {31'd0, scroll_valid}, 32'd0);
        chk("back_to_play", {31'd0, playing}, 32'd1);

        // Boundaries: exactly on scroll line, just above floor, one pixel above line.
        doodle_y = 10'd300;
        wait_tick();
        chk("line_no_scroll", {31'd0, scroll_valid}, 32'd0);
        doodle_y = 10'd687;
        wait_tick();
        chk("floor_minus1_play", {31'd0, playing}, 32'd1);
        chk("floor_minus1_over", {31'd0, game_over}, 32'd0);
        doodle_y = 10'd299;
        push_scroll(299);
        wait_tick();
        chk("scroll_by_1", {31'd0, scroll_valid}, 32'd1);

        // Maximum scrolls until the score saturates.
        doodle_y = 10'd0;
        for (int i = 0; i < 221; i++) begin
            push_scroll(0);
            wait_tick();
        end
        doodle_y = 10'd400;
        repeat (5) @(negedge clk);
        chk("score_saturated", {16'd0, score}, 32'h0000FFFF);
        chk("amount_held", {22'd0, scroll_amount}, 32'd300);

        // Fall off screen; restart only at the third OVER tick.
        doodle_y = 10'd700;
        wait_tick();
        chk("over_entry", {31'd0, game_over}, 32'd1);
        chk("over_not_playing", {31'd0, playing}, 32'd0);
        doodle_y = 10'd400;
        delta_x  = 9'd3;
        for (int t = 1; t <= 2; t++) begin
            wait_tick();
            chk("over_hold", {31'd0, game_over}, 32'd1);
            chk("over_no_soft_rst", {31'd0, soft_rst}, 32'd0);
        end
        wait_tick();
        model_score = 0;
        chk("restart_soft_rst", {31'd0, soft_rst}, 32'd1);
        chk("restart_score", {16'd0, score}, 32'd0);
        chk("restart_game_over", {31'd0, game_over}, 32'd0);
        chk("restart_playing", {31'd0, playing}, 32'd0);
        delta_x = '0;
        @(posedge clk); #1;
        chk("soft_rst_one_cycle", {31'd0, soft_rst}, 32'd0);

        // Reset during SCROLL.
        delta_x = 9'd5;
        wait_tick();
        delta_x  = '0;
        doodle_y = 10'd100;
        push_scroll(100);
        wait_tick();
        chk("scroll_before_rst", {31'd0, scroll_valid}, 32'd1);
        doodle_y = 10'd400;
        rst = 1'b1;
        @(posedge clk); #1;
        model_score = 0;
        chk_all_zero("rst_scroll");
        @(negedge clk);
        rst = 1'b0;

        // Reset during OVER.
        delta_x = 9'd5;
        wait_tick();
        delta_x  = '0;
        doodle_y = 10'd700;
        wait_tick();
        chk("over_before_rst", {31'd0, game_over}, 32'd1);
        doodle_y = 10'd400;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("rst_over");
        @(negedge clk);
        rst = 1'b0;
        wait_tick();
        chk("idle_after_rst", {31'd0, playing}, 32'd0);
        chk("no_soft_rst_after_rst", {31'd0, soft_rst}, 32'd0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
